register_write_arbiter: RTL and testbench
=========================================

Name: register_write_arbiter

Overview:
Owns the single write port of the RISC-V register file and shares it among three writers: ALU writeback, load/memory writeback and a debug port. It uses valid/ready handshakes, fixed-priority debug and round-robin between ALU and memory. It drops writes to x0 and optionally sweeps all registers to zero after reset. Its registered outputs drive the register file's writeRegisterIndex, writeRegisterData and shouldWrite directly; the file commits them on the following negedge.

Parameters:
DATA_WIDTH, 32, width of write data
INDEX_WIDTH, 5, width of register index; register count = 2^INDEX_WIDTH

Ports:
clk  input  1  single clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
aluWriteValid  input  1  ALU writeback request
aluWriteIndex  input  INDEX_WIDTH  ALU destination register
aluWriteData  input  DATA_WIDTH  ALU result
aluWriteReady  output  1  ALU request granted this cycle
memWriteValid  input  1  load writeback request
memWriteIndex  input  INDEX_WIDTH  load destination register
memWriteData  input  DATA_WIDTH  load data
memWriteReady  output  1  load request granted this cycle
debugWriteValid  input  1  debug write request
debugWriteIndex  input  INDEX_WIDTH  debug destination register
debugWriteData  input  DATA_WIDTH  debug data
debugWriteReady  output  1  debug request granted this cycle
writeRegisterIndex  output  INDEX_WIDTH  to register file, registered
writeRegisterData  output  DATA_WIDTH  to register file, registered
shouldWrite  output  1  to register file, registered
initDone  output  1  high once arbiter is in RUN, registered
denyCount  output  16  saturating count of cycles in which at least one valid requester was not granted

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: shouldWrite=0, writeRegisterIndex=0, writeRegisterData=0, denyCount=0, lastGrant=MEM (so ALU wins the first tie). State=INIT if REG_CLEAR_ON_RESET_EN is defined, else RUN. initIndex=1. initDone=0 when state is INIT, 1 when RUN.
- Reset mid-operation: all of the above reset values reapply on the same edge. Any handshake in that cycle is discarded and no write is issued.
- State INIT:
  - All ready outputs = 0.
  - Each posedge loads shouldWrite=1, writeRegisterIndex=initIndex, writeRegisterData=0, then increments initIndex.
  - On the edge that loads index 2^INDEX_WIDTH-1, state becomes RUN and initDone becomes 1.
  - The sweep therefore lasts 2^INDEX_WIDTH-1 cycles (31 by default).
- State RUN, grant (combinational from the current valids):
  - debugWriteValid has absolute priority.
  - Otherwise, if exactly one of ALU/mem is valid, it is granted.
  - If both are valid, the one not equal to lastGrant is granted.
  - At most one ready is high per cycle. A ready is never high without its valid.
- Handshake completes when valid && ready at posedge. Requesters hold valid, index and data stable until granted; retracting valid before grant is illegal.
- Latency: a grant at posedge N makes the output registers show the write in cycle N+1 (shouldWrite=1). The register file commits it at the negedge inside cycle N+1. A new grant is allowed every cycle.
- No grant in a cycle gives shouldWrite=0 on the next edge. Index and data hold their previous values.
- x0: a granted request with index 0 completes its handshake, but the next shouldWrite=0. Round-robin still updates.
- lastGrant updates only on ALU or mem grants; debug grants leave it unchanged.
- denyCount increments by 1 on any RUN cycle where some valid is not granted (including during a debug grant). It saturates at 0xFFFF. It does not count during INIT.

Optional Feature:
REG_CLEAR_ON_RESET_EN:
- Defined: the INIT sweep described above runs after every reset. initDone rises 31 cycles after reset release (default width).
- Undefined: there is no INIT state or initIndex. The block enters RUN directly, initDone=1 on the first posedge after reset release, and requests can be granted in that first cycle.

Test Plan:
1. Macro defined, reset released → 31 consecutive cycles of shouldWrite=1, index 1..31, data 0. All readies 0 throughout. initDone=1 after index 31 appears.
2. ALU alone valid, index 5, data 0xDEADBEEF → aluWriteReady=1 the same cycle. The next cycle shows shouldWrite=1, index 5, data 0xDEADBEEF.
3. ALU and mem both valid and held for 4 cycles after reset → grants ALU, mem, ALU, mem. denyCount=4.
4. Debug, ALU and mem all valid → debug granted first. ALU/mem order afterwards continues from lastGrant unchanged.
5. mem valid with index 0, data 0x1234 → memWriteReady=1, next shouldWrite=0, and round-robin now favours ALU.
6. Reset asserted in the cycle an ALU grant occurs → next cycle shouldWrite=0, denyCount=0. The macro-defined build restarts the sweep at index 1.

Source files
------------

// File: rtl/register_write_arbiter_if.sv
// Handshake and register-file write bundle shared between the three writers and the arbiter.
// The arbiter side uses the slave modport; requesters and the register file side use master.
interface register_write_arbiter_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5
);
    logic                   aluWriteValid;
    logic [INDEX_WIDTH-1:0] aluWriteIndex;
    logic [DATA_WIDTH-1:0]  aluWriteData;
    logic                   aluWriteReady;

    logic                   memWriteValid;
    logic [INDEX_WIDTH-1:0] memWriteIndex;
    logic [DATA_WIDTH-1:0]  memWriteData;
    logic                   memWriteReady;

    logic                   debugWriteValid;
    logic [INDEX_WIDTH-1:0] debugWriteIndex;
    logic [DATA_WIDTH-1:0]  debugWriteData;
    logic                   debugWriteReady;

    logic [INDEX_WIDTH-1:0] writeRegisterIndex;
    logic [DATA_WIDTH-1:0]  writeRegisterData;
    logic                   shouldWrite;
    logic                   initDone;
    logic [15:0]            denyCount;

    modport master (
        output aluWriteValid, aluWriteIndex, aluWriteData,
        output memWriteValid, memWriteIndex, memWriteData,
        output debugWriteValid, debugWriteIndex, debugWriteData,
        input  aluWriteReady, memWriteReady, debugWriteReady,
        input  writeRegisterIndex, writeRegisterData, shouldWrite, initDone, denyCount
    );

    modport slave (
        input  aluWriteValid, aluWriteIndex, aluWriteData,
        input  memWriteValid, memWriteIndex, memWriteData,
        input  debugWriteValid, debugWriteIndex, debugWriteData,
        output aluWriteReady, memWriteReady, debugWriteReady,
        output writeRegisterIndex, writeRegisterData, shouldWrite, initDone, denyCount
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Single register-file write port shared by debug (fixed priority), ALU and load writeback (round-robin).
// Optional post-reset zero sweep of x1..xN enabled by defining REG_CLEAR_ON_RESET_EN.
module register_write_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5
) (
    input  logic clk,
    input  logic reset,
    register_write_arbiter_if.slave bus
);

    localparam logic [INDEX_WIDTH-1:0] IDX_ZERO = '0;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

`ifdef REG_CLEAR_ON_RESET_EN
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    state_t                 r_state;
    logic [INDEX_WIDTH-1:0] r_initIndex;
`endif

    logic                   r_wrVld_p1;
    logic [INDEX_WIDTH-1:0] r_wrIndex_p1;
    logic [DATA_WIDTH-1:0]  r_wrData_p1;
    logic [15:0]            r_denyCount;
    logic                   r_lastGrantMem;
    logic                   r_initDone;

    logic                   w_run;
    logic                   w_aluReady;
    logic                   w_memReady;
    logic                   w_dbgReady;
    logic                   w_grantAny;
    logic                   w_deny;
    logic [INDEX_WIDTH-1:0] w_selIndex;
    logic [DATA_WIDTH-1:0]  w_selData;

`ifdef REG_CLEAR_ON_RESET_EN
    assign w_run = (r_state == ST_RUN);
`else
    assign w_run = 1'b1;
`endif

    // Debug always wins; on an ALU/mem tie the side that did not win last time goes.
    assign w_dbgReady = w_run && bus.debugWriteValid;
    assign w_aluReady = w_run && !bus.debugWriteValid && bus.aluWriteValid
                        && (!bus.memWriteValid || r_lastGrantMem);
    assign w_memReady = w_run && !bus.debugWriteValid && bus.memWriteValid
                        && (!bus.aluWriteValid || !r_lastGrantMem);
    assign w_grantAny = w_dbgReady || w_aluReady || w_memReady;

    assign w_deny = (bus.aluWriteValid   && !w_aluReady)
                 || (bus.memWriteValid   && !w_memReady)
                 || (bus.debugWriteValid && !w_dbgReady);

    always_comb begin
        w_selIndex = IDX_ZERO;
        w_selData  = '0;
        if (w_dbgReady) begin
            w_selIndex = bus.debugWriteIndex;
            w_selData  = bus.debugWriteData;
        end else if (w_aluReady) begin
            w_selIndex = bus.aluWriteIndex;
            w_selData  = bus.aluWriteData;
        end else if (w_memReady) begin
            w_selIndex = bus.memWriteIndex;
            w_selData  = bus.memWriteData;
        end
    end

    // Stage p1: registered write command presented to the register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrVld_p1     <= 1'b0;
            r_wrIndex_p1   <= IDX_ZERO;
            r_wrData_p1    <= '0;
            r_denyCount    <= 16'd0;
            r_lastGrantMem <= 1'b1;
            r_initDone     <= 1'b0;
`ifdef REG_CLEAR_ON_RESET_EN
            r_state        <= ST_INIT;
            r_initIndex    <= IDX_ONE;
`endif
        end else begin
`ifdef REG_CLEAR_ON_RESET_EN
            if (r_state == ST_INIT) begin
                r_wrVld_p1   <= 1'b1;
                r_wrIndex_p1 <= r_initIndex;
                r_wrData_p1  <= '0;
                r_initIndex  <= r_initIndex + IDX_ONE;
                if (r_initIndex == IDX_LAST) begin
                    r_state    <= ST_RUN;
                    r_initDone <= 1'b1;
                end
            end else begin
`endif
                r_initDone <= 1'b1;
                // x0 completes its handshake but never reaches the register file.
                if (w_grantAny && (w_selIndex != IDX_ZERO)) begin
                    r_wrVld_p1   <= 1'b1;
                    r_wrIndex_p1 <= w_selIndex;
                    r_wrData_p1  <= w_selData;
                end else begin
                    r_wrVld_p1   <= 1'b0;
                end
                if (w_aluReady) begin
                    r_lastGrantMem <= 1'b0;
                end else if (w_memReady) begin
                    r_lastGrantMem <= 1'b1;
                end
                if (w_deny) begin
                    r_denyCount <= sat_inc(r_denyCount);
                end
`ifdef REG_CLEAR_ON_RESET_EN
            end
`endif
        end
    end

    assign bus.aluWriteReady      = w_aluReady;
    assign bus.memWriteReady      = w_memReady;
    assign bus.debugWriteReady    = w_dbgReady;
    assign bus.shouldWrite        = r_wrVld_p1;
    assign bus.writeRegisterIndex = r_wrIndex_p1;
    assign bus.writeRegisterData  = r_wrData_p1;
    assign bus.initDone           = r_initDone;
    assign bus.denyCount          = r_denyCount;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter; expected values are hand-computed per step.
// Covers both builds of REG_CLEAR_ON_RESET_EN.
module tb_register_write_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    register_write_arbiter_if #(.DATA_WIDTH(32), .INDEX_WIDTH(5)) bus ();

    register_write_arbiter #(.DATA_WIDTH(32), .INDEX_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.aluWriteValid   = 1'b0; bus.aluWriteIndex   = '0; bus.aluWriteData   = '0;
        bus.memWriteValid   = 1'b0; bus.memWriteIndex   = '0; bus.memWriteData   = '0;
        bus.debugWriteValid = 1'b0; bus.debugWriteIndex = '0; bus.debugWriteData = '0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        step();
        reset = 1'b0;
`ifdef REG_CLEAR_ON_RESET_EN
        for (int i = 0; i < 31; i++) step();
`endif
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check("rst_shouldWrite", bus.shouldWrite, 0);
        check("rst_index", bus.writeRegisterIndex, 0);
        check("rst_data", bus.writeRegisterData, 0);
        check("rst_deny", bus.denyCount, 0);
        reset = 1'b0;

`ifdef REG_CLEAR_ON_RESET_EN
        check("rst_initDone", bus.initDone, 0);
        // Sweep: ALU held valid to prove readies stay low and nothing is counted.
        bus.aluWriteValid = 1'b1; bus.aluWriteIndex = 5'd7; bus.aluWriteData = 32'hAAAA5555;
        for (int i = 1; i <= 31; i++) begin
            #1;
            check("sweep_aluReady", bus.aluWriteReady, 0);
            step();
            check("sweep_shouldWrite", bus.shouldWrite, 1);
            check("sweep_index", bus.writeRegisterIndex, i);
            check("sweep_data", bus.writeRegisterData, 0);
            check("sweep_initDone", bus.initDone, (i == 31) ? 1 : 0);
        end
        idle_inputs();
        check("sweep_deny", bus.denyCount, 0);
`endif

        // ALU alone, granted in the first available cycle.
        bus.aluWriteValid = 1'b1; bus.aluWriteIndex = 5'd5; bus.aluWriteData = 32'hDEADBEEF;
        #1;
        check("alu_ready", bus.aluWriteReady, 1);
        check("alu_memReady", bus.memWriteReady, 0);
        step();
        idle_inputs();
        check("alu_initDone", bus.initDone, 1);
        check("alu_shouldWrite", bus.shouldWrite, 1);
        check("alu_index", bus.writeRegisterIndex, 5);
        check("alu_data", bus.writeRegisterData, 32'hDEADBEEF);
        check("alu_deny", bus.denyCount, 0);

        // Fresh reset so ALU wins the first tie; alternate A, M, A, M.
        reset_dut();
        bus.aluWriteValid = 1'b1; bus.aluWriteIndex = 5'd1; bus.aluWriteData = 32'h11;
        bus.memWriteValid = 1'b1; bus.memWriteIndex = 5'd2; bus.memWriteData = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_aluReady", bus.aluWriteReady, (i % 2 == 0) ? 1 : 0);
            check("rr_memReady", bus.memWriteReady, (i % 2 == 1) ? 1 : 0);
            step();
            check("rr_index", bus.writeRegisterIndex, (i % 2 == 0) ? 1 : 2);
            check("rr_data", bus.writeRegisterData, (i % 2 == 0) ? 32'h11 : 32'h22);
        end
        check("rr_deny", bus.denyCount, 4);

        // Debug beats both; afterwards ALU still next because lastGrant stays MEM.
        bus.debugWriteValid = 1'b1; bus.debugWriteIndex = 5'd3; bus.debugWriteData = 32'h33;
        #1;
        check("dbg_ready", bus.debugWriteReady, 1);
        check("dbg_aluReady", bus.aluWriteReady, 0);
        check("dbg_memReady", bus.memWriteReady, 0);
        step();
        bus.debugWriteValid = 1'b0;
        check("dbg_index", bus.writeRegisterIndex, 3);
        check("dbg_data", bus.writeRegisterData, 32'h33);
        check("dbg_deny", bus.denyCount, 5);
        #1;
        check("postdbg_aluReady", bus.aluWriteReady, 1);
        step();
        check("postdbg_index", bus.writeRegisterIndex, 1);
        #1;
        check("postdbg_memReady", bus.memWriteReady, 1);
        step();
        idle_inputs();
        check("postdbg_index2", bus.writeRegisterIndex, 2);
        check("postdbg_deny", bus.denyCount, 7);
        step();
        check("idle_shouldWrite", bus.shouldWrite, 0);
        check("idle_index_hold", bus.writeRegisterIndex, 2);
        check("idle_data_hold", bus.writeRegisterData, 32'h22);
        check("idle_deny", bus.denyCount, 7);

        // Make ALU the last winner, then a mem write to x0 flips preference back to ALU.
        bus.aluWriteValid = 1'b1; bus.aluWriteIndex = 5'd4; bus.aluWriteData = 32'h44;
        step();
        idle_inputs();
        check("pre_x0_index", bus.writeRegisterIndex, 4);
        bus.memWriteValid = 1'b1; bus.memWriteIndex = 5'd0; bus.memWriteData = 32'h1234;
        #1;
        check("x0_memReady", bus.memWriteReady, 1);
        step();
        idle_inputs();
        check("x0_shouldWrite", bus.shouldWrite, 0);
        bus.aluWriteValid = 1'b1; bus.aluWriteIndex = 5'd6; bus.aluWriteData = 32'h66;
        bus.memWriteValid = 1'b1; bus.memWriteIndex = 5'd7; bus.memWriteData = 32'h77;
        #1;
        check("x0_rr_aluReady", bus.aluWriteReady, 1);
        check("x0_rr_memReady", bus.memWriteReady, 0);
        step();
        idle_inputs();
        check("x0_rr_index", bus.writeRegisterIndex, 6);
        check("x0_rr_data", bus.writeRegisterData, 32'h66);
        check("x0_rr_deny", bus.denyCount, 8);

        // Reset during an ALU grant: the write is dropped and counters clear.
        bus.aluWriteValid = 1'b1; bus.aluWriteIndex = 5'd9; bus.aluWriteData = 32'h99;
        reset = 1'b1;
        #1;
        check("rstmid_aluReady", bus.aluWriteReady, 1);
        step();
        idle_inputs();
        reset = 1'b0;
        check("rstmid_shouldWrite", bus.shouldWrite, 0);
        check("rstmid_index", bus.writeRegisterIndex, 0);
        check("rstmid_deny", bus.denyCount, 0);
        step();
`ifdef REG_CLEAR_ON_RESET_EN
        check("rstmid_sweep_shouldWrite", bus.shouldWrite, 1);
        check("rstmid_sweep_index", bus.writeRegisterIndex, 1);
        check("rstmid_initDone", bus.initDone, 0);
`else
        check("rstmid_after_shouldWrite", bus.shouldWrite, 0);
        check("rstmid_initDone", bus.initDone, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
